imm_encoder: RTL
================

Name: imm_encoder

Overview:
Inverse of the decode-side immediate sign-extender. Takes a 32-bit signed immediate, an immediate format code and a base instruction word, and packs the immediate into the RISC-V instruction bit positions for that format. It flags out-of-range and misaligned immediates and keeps a saturating error count. The block is a 2-stage valid/ready pipeline used by the program loader and the self-check/test infrastructure to build instruction words.

Parameters:
CNT_W, 16, width of the saturating error counter.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
valid_i  in  1  input transaction valid
ready_o  out  1  block can accept input this cycle
imm_i  in  32  signed immediate value
immsrc_i  in  2  format: 00 I, 01 S, 10 B, 11 J (same coding as decode-side immsrc)
base_i  in  32  instruction word; bits outside the format's immediate fields pass through unchanged
valid_o  out  1  output transaction valid
ready_i  in  1  downstream accepts output
instr_o  out  32  packed instruction
range_err_o  out  1  immediate not representable in the format
align_err_o  out  1  imm_i[0]=1 for B or J
err_count_o  out  CNT_W  count of error transactions consumed downstream, saturating

Behaviour:
- Reset (rst_i high at a clock edge): both stage valids, valid_o, instr_o, range_err_o, align_err_o and err_count_o go to 0. In-flight transactions are discarded. ready_o is 1 in the first cycle after reset.
- Handshake: input is accepted on valid_i && ready_o. Output is consumed on valid_o && ready_i.
- Once valid_o is high, instr_o and both error flags stay stable until the output is consumed.
- Pipeline: stage1 registers imm_i, immsrc_i and base_i, and computes the error flags. Stage2 registers the packed word and flags and drives the outputs.
  - adv2 = !s2_valid || ready_i
  - adv1 = !s1_valid || adv2
  - ready_o = adv1 (combinational, no dependence on valid_i)
- Latency is 2 cycles from acceptance to valid_o under no back-pressure. Full throughput is 1 transaction per cycle. No bubbles or drops under any ready_i pattern.
- Packing. Every bit not listed for the format is taken from base_i.
  - I: instr[31:20]=imm[11:0]
  - S: instr[31:25]=imm[11:5]; instr[11:7]=imm[4:0]
  - B: instr[31]=imm[12]; instr[30:25]=imm[10:5]; instr[11:8]=imm[4:1]; instr[7]=imm[11]
  - J: instr[31]=imm[20]; instr[30:21]=imm[10:1]; instr[20]=imm[11]; instr[19:12]=imm[19:12]
- Range check. range_err is set when any bit in the listed range differs from the next bit below it (i.e. the top bits are not a sign extension):
  - I/S: imm[31:11] not all equal
  - B: imm[31:12] not all equal
  - J: imm[31:20] not all equal
- Alignment: align_err = imm[0] for B and J; always 0 for I and S. imm[0] is dropped from the B/J encoding in all cases.
- On error, instr_o is still packed from the truncated bits; no substitution.
- Round-trip property: when neither flag is set, decode-side sign extension of instr_o with the same immsrc returns imm_i exactly.
- err_count_o increments by 1 on each consumed output with range_err_o || align_err_o. It holds at 2^CNT_W-1.
- The counter updates in the cycle after consumption. Reset has priority over an increment in the same cycle.

Decomposition:
- Shared package: the immsrc_t enum (IMM_I, IMM_S, IMM_B, IMM_J), shared with the decode-side sign-extender and control unit.
- Sub-module imm_pack_comb: pure combinational packing plus range/alignment check, instantiated between stage1 and stage2. It is formally checkable against the sign-extender for the round-trip property.

Test Plan:
- I: base 0x00000013, imm 0xFFFFFFFF -> instr_o 0xFFF00013, no errors, valid_o exactly 2 cycles after accept.
- S and B: S with base 0x00002023, imm 0xFFFFF801 -> 0x800020A3. B with base 0x00000063, imm 0xFFFFFFFC -> 0xFE000EE3. No errors for either.
- J and errors:
  - J base 0x0000006F, imm 0x00000800 -> 0x0010006F.
  - J imm 0x00100000 -> range_err_o=1.
  - B imm 0x00000003 -> align_err_o=1, range_err_o=0.
  - err_count_o = 2 after both errored outputs are consumed.
- Back-pressure: 8 back-to-back inputs with random ready_i (including 5 low cycles in a row) -> all 8 outputs in order, bit-exact, ready_o low while both stages are full, outputs stable while stalled.
- Saturation: CNT_W=2, 5 erroring transactions -> err_count_o = 3 and holds.
- Reset mid-flight: 2 transactions in the pipe, rst_i high 1 cycle -> valid_o=0, err_count_o=0 next cycle, then a fresh I transaction completes with 2-cycle latency.

Source files
------------

// File: rtl/imm_encoder_pkg.sv
// Shared immediate-format definitions for the encode and decode sides.
// Also holds the representability check used by the packer.
package imm_encoder_pkg;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } immsrc_t;

    localparam int XLEN = 32;

    // True when every bit from position msb_keep upward equals bit msb_keep,
    // i.e. the value survives truncation to msb_keep+1 bits plus sign extension.
    function automatic logic fits_signed(input logic [XLEN-1:0] value, input int msb_keep);
        logic signed [XLEN-1:0] shifted;
        shifted = $signed(value) >>> msb_keep;
        return (shifted == '0) || (shifted == '1);
    endfunction

endpackage

// File: rtl/imm_encoder_if.sv
// Request/response bundle of the immediate encoder.
// The slave modport is the encoder's view; master is the driver's view.
interface imm_encoder_if #(parameter int CNT_W = 16) ();
    import imm_encoder_pkg::*;

    logic             valid_i;
    logic             ready_o;
    logic [31:0]      imm_i;
    immsrc_t          immsrc_i;
    logic [31:0]      base_i;
    logic             valid_o;
    logic             ready_i;
    logic [31:0]      instr_o;
    logic             range_err_o;
    logic             align_err_o;
    logic [CNT_W-1:0] err_count_o;

    modport slave (
        input  valid_i, imm_i, immsrc_i, base_i, ready_i,
        output ready_o, valid_o, instr_o, range_err_o, align_err_o, err_count_o
    );

    modport master (
        output valid_i, imm_i, immsrc_i, base_i, ready_i,
        input  ready_o, valid_o, instr_o, range_err_o, align_err_o, err_count_o
    );

endinterface

// File: rtl/imm_encoder_pack_comb.sv
// Purely combinational immediate packer: scatters the immediate into the
// RISC-V field positions of the chosen format and flags range/alignment faults.
module imm_pack_comb
    import imm_encoder_pkg::*;
(
    input  logic [31:0] imm,
    input  immsrc_t     immsrc,
    input  logic [31:0] base,
    output logic [31:0] instr,
    output logic        range_err,
    output logic        align_err
);

    // Fields not owned by the format fall through from base; imm[0] of B/J
    // is never encoded, so a set bit there only raises align_err.
    always_comb begin
        instr     = base;
        range_err = 1'b0;
        align_err = 1'b0;
        case (immsrc)
            IMM_I: begin
                instr[31:20] = imm[11:0];
                range_err    = !fits_signed(imm, 11);
            end
            IMM_S: begin
                instr[31:25] = imm[11:5];
                instr[11:7]  = imm[4:0];
                range_err    = !fits_signed(imm, 11);
            end
            IMM_B: begin
                instr[31]    = imm[12];
                instr[30:25] = imm[10:5];
                instr[11:8]  = imm[4:1];
                instr[7]     = imm[11];
                range_err    = !fits_signed(imm, 12);
                align_err    = imm[0];
            end
            default: begin
                instr[31]    = imm[20];
                instr[30:21] = imm[10:1];
                instr[20]    = imm[11];
                instr[19:12] = imm[19:12];
                range_err    = !fits_signed(imm, 20);
                align_err    = imm[0];
            end
        endcase
    end

endmodule

// File: rtl/imm_encoder.sv
// Two-stage valid/ready pipeline that packs immediates into instruction words
// and keeps a saturating count of errored transactions handed downstream.
module imm_encoder
    import imm_encoder_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    imm_encoder_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             s1_valid;
    logic [31:0]      s1_imm;
    immsrc_t          s1_src;
    logic [31:0]      s1_base;

    logic             s2_valid;
    logic [31:0]      s2_instr;
    logic             s2_range;
    logic             s2_align;

    logic [CNT_W-1:0] err_cnt;

    logic [31:0]      pk_instr;
    logic             pk_range;
    logic             pk_align;

    logic             adv1;
    logic             adv2;
    logic             consume;

    assign adv2    = !s2_valid || bus.ready_i;
    assign adv1    = !s1_valid || adv2;
    assign consume = s2_valid && bus.ready_i;

    imm_pack_comb u_pack (
        .imm       (s1_imm),
        .immsrc    (s1_src),
        .base      (s1_base),
        .instr     (pk_instr),
        .range_err (pk_range),
        .align_err (pk_align)
    );

    // Stage 1 captures the raw request; payload only loads on an accepted beat.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid <= 1'b0;
            s1_imm   <= '0;
            s1_src   <= IMM_I;
            s1_base  <= '0;
        end else if (adv1) begin
            s1_valid <= bus.valid_i;
            if (bus.valid_i) begin
                s1_imm  <= bus.imm_i;
                s1_src  <= bus.immsrc_i;
                s1_base <= bus.base_i;
            end
        end
    end

    // Stage 2 holds the packed word steady while downstream stalls.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s2_valid <= 1'b0;
            s2_instr <= '0;
            s2_range <= 1'b0;
            s2_align <= 1'b0;
        end else if (adv2) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_instr <= pk_instr;
                s2_range <= pk_range;
                s2_align <= pk_align;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_cnt <= '0;
        end else if (consume && (s2_range || s2_align) && (err_cnt != CNT_MAX)) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end

    assign bus.ready_o     = adv1;
    assign bus.valid_o     = s2_valid;
    assign bus.instr_o     = s2_instr;
    assign bus.range_err_o = s2_range;
    assign bus.align_err_o = s2_align;
    assign bus.err_count_o = err_cnt;

endmodule
